// File: rtl/gpu_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : gpu_pixel_writer
// Purpose  : Clips rasteriser pixels to the screen, converts them to linear
//            framebuffer addresses, buffers them in a small FIFO and drains
//            the FIFO into SRAM one write per wr_en/ack handshake.
// Revision : 1.0 - initial release
// ============================================================================
module gpu_pixel_writer #(
  parameter int WIDTH_BITS   = 10,
  parameter int HEIGHT_BITS  = 9,
  parameter int CHANNEL_BITS = 8,
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int ADDR_BITS    = 19,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      pix_valid,
  input  logic [WIDTH_BITS-1:0]     X,
  input  logic [HEIGHT_BITS-1:0]    Y,
  input  logic [CHANNEL_BITS-1:0]   r_i,
  input  logic [CHANNEL_BITS-1:0]   g_i,
  input  logic [CHANNEL_BITS-1:0]   b_i,
  output logic                      pix_ready,
  output logic                      mem_wr_en,
  output logic [ADDR_BITS-1:0]      mem_addr,
  output logic [3*CHANNEL_BITS-1:0] mem_wdata,
  input  logic                      mem_ack,
  output logic                      idle,
  output logic [7:0]                drop_cnt
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int DATA_W  = 3 * CHANNEL_BITS;
  localparam int ENTRY_W = ADDR_BITS + DATA_W;

  // One spare bit so a screen size equal to 2**bits still compares correctly
  localparam logic [WIDTH_BITS:0]  c_width_x  = (WIDTH_BITS + 1)'(WIDTH);
  localparam logic [HEIGHT_BITS:0] c_height_y = (HEIGHT_BITS + 1)'(HEIGHT);
  localparam logic [ADDR_BITS-1:0] c_width_a  = ADDR_BITS'(WIDTH);
  localparam logic [CNT_W-1:0]     c_full_cnt = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_wr_en;
  logic                    w_wr_en_nxt;
  logic [ADDR_BITS-1:0]    r_addr;
  logic [DATA_W-1:0]       r_wdata;
  logic [7:0]              r_drop_cnt;

  logic [ENTRY_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_accept;
  logic                    w_in_range;
  logic                    w_push;
  logic                    w_drop;
  logic                    w_pop;
  logic [ADDR_BITS-1:0]    w_addr;
  logic [ENTRY_W-1:0]      w_head;

  assign w_full     = (r_count == c_full_cnt);
  assign w_empty    = (r_count == '0);
  assign pix_ready  = !w_full;
  assign w_accept   = pix_valid && pix_ready;
  assign w_in_range = ({1'b0, X} < c_width_x) && ({1'b0, Y} < c_height_y);
  assign w_push     = w_accept && w_in_range;
  assign w_drop     = w_accept && !w_in_range;
  // Only in-range pixels are stored, so the product never exceeds WIDTH*HEIGHT-1
  assign w_addr     = ADDR_BITS'(Y) * c_width_a + ADDR_BITS'(X);
  assign w_head     = r_mem[r_rd_ptr];

  assign mem_wr_en  = r_wr_en;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign drop_cnt   = r_drop_cnt;
  assign idle       = w_empty && (r_state == ST_IDLE);

  // FIFO storage write; contents need no reset because occupancy gates reads
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {w_addr, r_i, g_i, b_i};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating count of pixels rejected by the screen clip
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Write FSM next state: pop the head whenever the write slot is free or just acked
  always_comb begin
    w_state_nxt = r_state;
    w_wr_en_nxt = r_wr_en;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_wr_en_nxt = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (mem_ack) begin
          if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_wr_en_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_wr_en_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write FSM registers; address and data only change when an entry is popped
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_state <= ST_IDLE;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wr_en <= w_wr_en_nxt;
      if (w_pop) begin
        r_addr  <= w_head[ENTRY_W-1 -: ADDR_BITS];
        r_wdata <= w_head[DATA_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpu_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpu_pixel_writer
// Purpose  : Directed self-checking bench for gpu_pixel_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpu_pixel_writer;

  logic        clk;
  logic        n_rst;
  logic        pix_valid;
  logic [9:0]  X;
  logic [8:0]  Y;
  logic [7:0]  r_i;
  logic [7:0]  g_i;
  logic [7:0]  b_i;
  logic        pix_ready;
  logic        mem_wr_en;
  logic [18:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_ack;
  logic        idle;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Every completed write (wr_en and ack together, outside reset), as {addr, data}
  logic [42:0] wr_log[$];

  gpu_pixel_writer dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .pix_valid (pix_valid),
    .X         (X),
    .Y         (Y),
    .r_i       (r_i),
    .g_i       (g_i),
    .b_i       (b_i),
    .pix_ready (pix_ready),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .idle      (idle),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record completed writes
  always @(posedge clk) begin
    if (!n_rst && mem_wr_en && mem_ack) begin
      wr_log.push_back({mem_addr, mem_wdata});
    end
  end

  // Present one pixel and hold it until the edge that accepts it
  task automatic send_px(input int x, input int y, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b);
    int t;
    X = 10'(x); Y = 9'(y); r_i = r; g_i = g; b_i = b;
    pix_valid = 1'b1;
    t = 0;
    while (!pix_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!pix_ready) begin
      n_checks++; n_errors++;
      $display("FAIL send_timeout: pix_ready=%0b required 1 within 50 cycles", pix_ready);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic test_reset;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_wr_en, mem_addr, mem_wdata, drop_cnt, pix_ready, idle} !==
        {1'b0, 19'd0, 24'd0, 8'd0, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_state: wr_en=%0b addr=%0d wdata=%h drop=%0d ready=%0b idle=%0b required 0 0 000000 0 1 1",
               mem_wr_en, mem_addr, mem_wdata, drop_cnt, pix_ready, idle);
    end
    n_rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write;
    send_px(3, 2, 8'h11, 8'h22, 8'h33);
    n_checks++;
    if (mem_wr_en !== 1'b0) begin
      n_errors++;
      $display("FAIL latency_edge1: wr_en=%0b required 0", mem_wr_en);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 19'd1283, 24'h112233}) begin
      n_errors++;
      $display("FAIL single_write: wr_en=%0b addr=%0d wdata=%h required 1 1283 112233",
               mem_wr_en, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_checks++;
    if ({mem_wr_en, idle} !== 2'b01) begin
      n_errors++;
      $display("FAIL single_done: wr_en=%0b idle=%0b required 0 1", mem_wr_en, idle);
    end
  endtask

  task automatic test_clip;
    send_px(639, 0,   8'hA1, 8'hA2, 8'hA3);
    send_px(0,   479, 8'hB1, 8'hB2, 8'hB3);
    send_px(640, 0,   8'hC1, 8'hC2, 8'hC3);
    send_px(0,   480, 8'hD1, 8'hD2, 8'hD3);
    n_checks++;
    if (drop_cnt !== 8'd2) begin
      n_errors++;
      $display("FAIL clip_drop_cnt: drop=%0d required 2", drop_cnt);
    end
    n_checks++;
    if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 19'd639, 24'hA1A2A3}) begin
      n_errors++;
      $display("FAIL clip_write0: wr_en=%0b addr=%0d wdata=%h required 1 639 a1a2a3",
               mem_wr_en, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    n_checks++;
    if ({mem_wr_en, mem_addr, mem_wdata} !== {1'b1, 19'd306560, 24'hB1B2B3}) begin
      n_errors++;
      $display("FAIL clip_write1: wr_en=%0b addr=%0d wdata=%h required 1 306560 b1b2b3",
               mem_wr_en, mem_addr, mem_wdata);
    end
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_wr_en, idle} !== 2'b01) begin
      n_errors++;
      $display("FAIL clip_no_more_writes: wr_en=%0b idle=%0b required 0 1", mem_wr_en, idle);
    end
  endtask

  task automatic test_back_to_back;
    logic [42:0] exp_log [5];
    exp_log[0] = {19'd650,  24'h102030};
    exp_log[1] = {19'd1300, 24'h112131};
    exp_log[2] = {19'd1950, 24'h122232};
    exp_log[3] = {19'd2600, 24'h132333};
    exp_log[4] = {19'd3250, 24'h142434};
    wr_log.delete();
    for (int i = 0; i < 5; i++) begin
      send_px(10 * (i + 1), i + 1, 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i));
    end
    n_checks++;
    if ({pix_ready, mem_wr_en, mem_addr} !== {1'b0, 1'b1, 19'd650}) begin
      n_errors++;
      $display("FAIL full_after_5: ready=%0b wr_en=%0b addr=%0d required 0 1 650",
               pix_ready, mem_wr_en, mem_addr);
    end
    // Sixth pixel must be refused while full
    X = 10'd60; Y = 9'd6; pix_valid = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({pix_ready, mem_addr} !== {1'b0, 19'd650}) begin
      n_errors++;
      $display("FAIL full_hold: ready=%0b addr=%0d required 0 650", pix_ready, mem_addr);
    end
    pix_valid = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (mem_wr_en !== (i < 4)) begin
        n_errors++;
        $display("FAIL b2b_wr_en[%0d]: wr_en=%0b required %0b", i, mem_wr_en, (i < 4));
      end
    end
    mem_ack = 1'b0;
    n_checks++;
    if (wr_log.size() !== 5) begin
      n_errors++;
      $display("FAIL b2b_count: writes=%0d required 5", wr_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (wr_log[i] !== exp_log[i]) begin
          n_errors++;
          $display("FAIL b2b_order[%0d]: addr=%0d wdata=%h required addr=%0d wdata=%h",
                   i, wr_log[i][42:24], wr_log[i][23:0], exp_log[i][42:24], exp_log[i][23:0]);
        end
      end
    end
  endtask

  task automatic test_drop_saturate;
    bit bad;
    bad = 1'b0;
    X = 10'd640; Y = 9'd480; pix_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (mem_wr_en || !idle || !pix_ready) bad = 1'b1;
      if (i == 9) begin
        n_checks++;
        if (drop_cnt !== 8'd12) begin
          n_errors++;
          $display("FAIL drop_midway: drop=%0d required 12", drop_cnt);
        end
      end
    end
    pix_valid = 1'b0;
    n_checks++;
    if (drop_cnt !== 8'd255) begin
      n_errors++;
      $display("FAIL drop_saturate: drop=%0d required 255", drop_cnt);
    end
    n_checks++;
    if (bad !== 1'b0) begin
      n_errors++;
      $display("FAIL drop_quiet: activity seen=%0b required 0", bad);
    end
  endtask

  task automatic test_reset_mid_write;
    for (int i = 0; i < 4; i++) begin
      send_px(100 + i, 0, 8'h55, 8'h66, 8'h77);
    end
    n_checks++;
    if ({mem_wr_en, idle, mem_addr} !== {1'b1, 1'b0, 19'd100}) begin
      n_errors++;
      $display("FAIL pre_reset: wr_en=%0b idle=%0b addr=%0d required 1 0 100",
               mem_wr_en, idle, mem_addr);
    end
    wr_log.delete();
    n_rst = 1'b1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({mem_wr_en, idle, pix_ready, drop_cnt, mem_addr} !==
        {1'b0, 1'b1, 1'b1, 8'd0, 19'd0}) begin
      n_errors++;
      $display("FAIL mid_reset: wr_en=%0b idle=%0b ready=%0b drop=%0d addr=%0d required 0 1 1 0 0",
               mem_wr_en, idle, pix_ready, drop_cnt, mem_addr);
    end
    n_rst = 1'b0;
    mem_ack = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_wr_en, idle, wr_log.size()} !== {1'b0, 1'b1, 32'd0}) begin
      n_errors++;
      $display("FAIL post_reset_flushed: wr_en=%0b idle=%0b writes=%0d required 0 1 0",
               mem_wr_en, idle, wr_log.size());
    end
  endtask

  initial begin
    n_rst = 1'b1; pix_valid = 1'b0; mem_ack = 1'b0;
    X = '0; Y = '0; r_i = '0; g_i = '0; b_i = '0;
    test_reset();
    test_single_write();
    test_clip();
    test_back_to_back();
    test_drop_saturate();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
